// File: rtl/aes_inv_top.sv
// AES-128 inverse cipher core: ten clocks of forward key expansion into a round-key
// array, then ten inverse rounds, one per clock. Handshake matches the encrypt core.

package aes_inv_pkg;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] a12;
        logic [7:0] p;
        a2  = gf_mul(a, a);
        a3  = gf_mul(a2, a);
        a12 = gf_mul(a3, a3);
        a12 = gf_mul(a12, a12);
        p   = gf_mul(a12, a3);
        for (int i = 0; i < 4; i++) p = gf_mul(p, p);
        return gf_mul(gf_mul(p, a12), a2);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
        logic [7:0] a0;
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        {a0, a1, a2, a3} = w;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

endpackage

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;

    logic [7:0] b;

    always_comb begin
        b = gf_inv(a);
        y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

module aes_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    import aes_inv_pkg::*;

    logic [7:0] b;

    always_comb begin
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        y = gf_inv(b);
    end
endmodule

module aes_inv_top #(
    parameter int NR    = 10,
    parameter int KEY_W = 128
) (
    input  logic             AES_clk,
    input  logic             AES_rst_n,
    input  logic             AES_en,
    input  logic [127:0]     AES_data_in,
    input  logic [KEY_W-1:0] AES_key_in,
    output logic [127:0]     AES_data_out,
    output logic             AES_data_out_valid,
    output logic             AES_busy
);
    import aes_inv_pkg::*;

    // state | meaning
    // IDLE  | waiting for AES_en; AES_data_out holds the last result
    // KEXP  | cnt=1..10: derive rk[cnt] from rk[cnt-1]
    // ROUND | cnt=9..0: one inverse round with rk[cnt]; cnt=0 is the final round
    typedef enum logic [1:0] {IDLE, KEXP, ROUND} fsm_t;

    if (NR != 10 || KEY_W != 128) begin : g_bad_cfg
        $error("aes_inv_top supports only NR=10 and KEY_W=128");
    end

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q [0:10];
    logic [127:0] rk_d [0:10];
    logic [127:0] data_out_q, data_out_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;

    logic [127:0] rk_cur, rk_prev, rk_next;
    logic [127:0] isr, isb, ark, imc;
    logic [31:0]  rot_w, sub_w, t_w;
    logic [7:0]   rcon;

    always_comb begin
        rk_cur  = '0;
        rk_prev = '0;
        for (int i = 0; i <= 10; i++) begin
            if (cnt_q == 4'(i)) rk_cur = rk_q[i];
        end
        for (int i = 0; i < 10; i++) begin
            if (cnt_q == 4'(i + 1)) rk_prev = rk_q[i];
        end
    end

    // Forward key schedule step on the last word of the previous round key.
    assign rot_w = {rk_prev[23:0], rk_prev[31:24]};

    for (genvar g = 0; g < 4; g++) begin : g_sub_word
        aes_sbox u_sbox (.a(rot_w[31-8*g -: 8]), .y(sub_w[31-8*g -: 8]));
    end

    always_comb begin
        case (cnt_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        t_w               = sub_w ^ {rcon, 24'h000000};
        rk_next[127:96]   = rk_prev[127:96] ^ t_w;
        rk_next[95:64]    = rk_prev[95:64]  ^ rk_next[127:96];
        rk_next[63:32]    = rk_prev[63:32]  ^ rk_next[95:64];
        rk_next[31:0]     = rk_prev[31:0]   ^ rk_next[63:32];
    end

    // Byte (r, c) sits at index r + 4c; row r rotates right by r columns.
    always_comb begin
        isr = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr[127-8*(r+4*c) -: 8] = state_q[127-8*(r+4*((c-r+4)%4)) -: 8];
            end
        end
    end

    for (genvar g = 0; g < 16; g++) begin : g_inv_sub
        aes_inv_sbox u_inv_sbox (.a(isr[127-8*g -: 8]), .y(isb[127-8*g -: 8]));
    end

    always_comb begin
        ark = isb ^ rk_cur;
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
    end

    always_comb begin
        fsm_d      = fsm_q;
        cnt_d      = cnt_q;
        state_d    = state_q;
        rk_d       = rk_q;
        data_out_d = data_out_q;
        valid_d    = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (AES_en) begin
                    state_d  = AES_data_in;
                    rk_d[0]  = AES_key_in;
                    cnt_d    = 4'd1;
                    fsm_d    = KEXP;
                end
            end
            KEXP: begin
                for (int i = 1; i <= 10; i++) begin
                    if (cnt_q == 4'(i)) rk_d[i] = rk_next;
                end
                if (cnt_q == 4'd10) begin
                    state_d = state_q ^ rk_next;
                    cnt_d   = 4'd9;
                    fsm_d   = ROUND;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                if (cnt_q == 4'd0) begin
                    data_out_d = ark;
                    valid_d    = 1'b1;
                    fsm_d      = IDLE;
                end else begin
                    state_d = imc;
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            default: fsm_d = IDLE;
        endcase
        // Busy drops on the same edge that raises valid.
        busy_d = (fsm_q != IDLE) && (fsm_d != IDLE);
    end

    always_ff @(posedge AES_clk or negedge AES_rst_n) begin
        if (!AES_rst_n) begin
            fsm_q      <= IDLE;
            cnt_q      <= 4'd0;
            state_q    <= '0;
            for (int i = 0; i <= 10; i++) rk_q[i] <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            rk_q       <= rk_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    assign AES_data_out       = data_out_q;
    assign AES_data_out_valid = valid_q;
    assign AES_busy           = busy_q;

endmodule

// File: tb/tb_aes_inv_top.sv
// Bench for aes_inv_top: FIPS vectors, held-enable, mid-block reset, and loopback
// against a byte-level AES-128 encryption model.

module tb_aes_inv_top;

    logic         clk;
    logic         rst_n;
    logic         en;
    logic [127:0] din;
    logic [127:0] kin;
    logic [127:0] dout;
    logic         vld;
    logic         busy;

    int n_checks;
    int n_errors;

    logic [7:0] sbox [256];
    logic [7:0] ks   [176];

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
    localparam logic [127:0] VLD_AT_20 = 128'h100000;

    aes_inv_top dut (
        .AES_clk            (clk),
        .AES_rst_n          (rst_n),
        .AES_en             (en),
        .AES_data_in        (din),
        .AES_key_in         (kin),
        .AES_data_out       (dout),
        .AES_data_out_valid (vld),
        .AES_busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // S-box by walking generator 3 and its inverse in lockstep.
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sbox[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sbox[0] = 8'h63;
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [7:0] t [4];
        logic [7:0] rc;
        logic [7:0] tmp;
        for (int i = 0; i < 16; i++) ks[i] = key[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) t[j] = ks[i-4+j];
            if (i % 16 == 0) begin
                tmp  = t[0];
                t[0] = sbox[t[1]] ^ rc;
                t[1] = sbox[t[2]];
                t[2] = sbox[t[3]];
                t[3] = sbox[tmp];
                rc   = xt(rc);
            end
            for (int j = 0; j < 4; j++) ks[i+j] = ks[i-16+j] ^ t[j];
        end
    endtask

    function automatic logic [127:0] model_enc(input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   u [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[i];
        for (int rd = 1; rd <= 10; rd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    u[r+4*c] = s[r+4*((c+r)%4)];
            for (int c = 0; c < 4; c++) begin
                a0 = u[4*c]; a1 = u[4*c+1]; a2 = u[4*c+2]; a3 = u[4*c+3];
                if (rd < 10) begin
                    s[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                    s[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[16*rd+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One block from the accepting edge (0) through edge 20; inputs scrambled after edge 1.
    task automatic run_block(input logic [127:0] ct, input logic [127:0] key,
                             output logic [127:0] res, output logic [20:0] busy_m,
                             output logic [20:0] vld_m);
        @(negedge clk);
        en  = 1'b1;
        din = ct;
        kin = key;
        @(posedge clk);
        #1;
        en = 1'b0;
        busy_m    = '0;
        vld_m     = '0;
        busy_m[0] = busy;
        vld_m[0]  = vld;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2) begin
                din = rand128();
                kin = rand128();
            end
            @(posedge clk);
            #1;
            busy_m[k] = busy;
            vld_m[k]  = vld;
        end
        res = dout;
    endtask

    initial begin : main
        logic [127:0] res, pt, key, ct;
        logic [20:0]  bm, vm;
        logic [62:0]  vm3, exp3;
        logic [24:0]  vmr;

        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        din   = '0;
        kin   = '0;
        build_sbox();
        #1;
        check("rst_data_out", dout, '0);
        check("rst_valid", 128'(vld), '0);
        check("rst_busy", 128'(busy), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        model_expand(KEY_B);
        check("model_selftest", model_enc(PT_B), CT_B);

        run_block(CT_C1, KEY_C1, res, bm, vm);
        check("c1_result", res, PT_C1);
        check("c1_busy_profile", 128'(bm), 128'h0FFFFE);
        check("c1_valid_profile", 128'(vm), VLD_AT_20);

        run_block(CT_B, KEY_B, res, bm, vm);
        check("b_result", res, PT_B);
        check("b_valid_profile", 128'(vm), VLD_AT_20);

        // Reset dropped mid-block while dout still holds PT_B.
        @(negedge clk);
        en  = 1'b1;
        din = CT_C1;
        kin = KEY_C1;
        @(posedge clk);
        #1;
        en = 1'b0;
        repeat (12) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_data_out", dout, '0);
        check("midrst_busy", 128'(busy), '0);
        check("midrst_valid", 128'(vld), '0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vmr = '0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            vmr[k] = vld;
        end
        check("midrst_no_valid", 128'(vmr), '0);
        check("midrst_out_held", dout, '0);
        run_block(CT_C1, KEY_C1, res, bm, vm);
        check("restart_result", res, PT_C1);
        check("restart_valid_profile", 128'(vm), VLD_AT_20);

        // Enable held high for 60 cycles: blocks accepted at edges 0, 21, 42.
        @(negedge clk);
        en  = 1'b1;
        din = CT_Z;
        kin = '0;
        vm3 = '0;
        for (int k = 0; k <= 62; k++) begin
            @(posedge clk);
            #1;
            vm3[k] = vld;
            if (vld) check($sformatf("held_result_%0d", k), dout, '0);
            if (k == 59) en = 1'b0;
        end
        exp3     = '0;
        exp3[20] = 1'b1;
        exp3[41] = 1'b1;
        exp3[62] = 1'b1;
        check("held_valid_profile", 128'(vm3), 128'(exp3));

        key = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
        pt  = 128'h000000f0_00000000_00000000_00000000;
        model_expand(key);
        ct = model_enc(pt);
        run_block(ct, key, res, bm, vm);
        check("loop_fixed", res, pt);

        for (int n = 0; n < 200; n++) begin
            key = rand128();
            pt  = rand128();
            model_expand(key);
            ct = model_enc(pt);
            run_block(ct, key, res, bm, vm);
            check($sformatf("loop_rand_%0d", n), res, pt);
            check($sformatf("loop_rand_valid_%0d", n), 128'(vm), VLD_AT_20);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
